net_inject_tx: RTL and testbench

NET_INJECT_TX -- requirements
Module: net_inject_tx

---
 rtl/net_inject_tx_if.sv | 21 ++
 rtl/net_inject_tx.sv | 44 ++++
 tb/tb_net_inject_tx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/net_inject_tx_if.sv
// net_inject_tx_if: core request, router write and status signals of the injection block (master = core/router side, slave = block)
interface net_inject_tx_if;
  logic        core_valid;
  logic [3:0]  core_dest;
  logic [55:0] core_payload;
  logic        core_ready;
  logic        router_full;
  logic [63:0] flit_out;
  logic        flit_wr_en;
  logic        drop_pulse;
  logic [15:0] sent_count;
  logic [3:0]  q_count;
  modport master (
    output core_valid, core_dest, core_payload, router_full,
    input  core_ready, flit_out, flit_wr_en, drop_pulse, sent_count, q_count
  );
  modport slave (
    input  core_valid, core_dest, core_payload, router_full,
    output core_ready, flit_out, flit_wr_en, drop_pulse, sent_count, q_count
  );
endinterface

// File: rtl/net_inject_tx.sv
// net_inject_tx: stamps SRC_ADDR on core requests, queues them in a DEPTH-entry FIFO and writes one flit per cycle to the router unless router_full; ports clk, rst, bus (core request in, flit/wr_en/drop_pulse/sent_count/q_count out)
module net_inject_tx #(
  parameter logic [3:0] SRC_ADDR = 4'd0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  net_inject_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_Q = 4'(DEPTH);
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic accept, push, pop;
  always_comb begin
    bus.core_ready = (bus.q_count < DEPTH_Q) && !rst;
    accept = bus.core_valid && bus.core_ready;
    push = accept && (bus.core_dest != SRC_ADDR);
    pop = (bus.q_count != 4'd0) && !bus.router_full;
  end
  always_ff @(posedge clk)
    if (push) mem[tail] <= {bus.core_payload, bus.core_dest, SRC_ADDR};
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.flit_out <= 64'h0;
      bus.flit_wr_en <= 1'b0;
      bus.drop_pulse <= 1'b0;
      bus.sent_count <= 16'h0;
      bus.q_count <= 4'd0;
      head <= '0;
      tail <= '0;
    end else begin
      bus.flit_wr_en <= pop;
      bus.drop_pulse <= accept && (bus.core_dest == SRC_ADDR);
      if (pop) begin
        bus.flit_out <= mem[head];
        head <= head + AW'(1);
        bus.sent_count <= bus.sent_count + 16'd1;
      end
      if (push) tail <= tail + AW'(1);
      bus.q_count <= bus.q_count + 4'(push) - 4'(pop);
    end
  end
endmodule

// File: tb/tb_net_inject_tx.sv
// tb_net_inject_tx: directed and random stimulus against a queue-based reference model of the injection block
module tb_net_inject_tx;
  localparam logic [3:0] SRC = 4'd1;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] q[$];
  logic [63:0] exp_flit = 64'h0;
  logic exp_wr = 1'b0;
  logic exp_drop = 1'b0;
  logic [15:0] sent = 16'h0;
  logic acc;
  net_inject_tx_if bus();
  net_inject_tx #(.SRC_ADDR(SRC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic compare_all();
    chk("flit_wr_en", 64'(bus.flit_wr_en), 64'(exp_wr));
    chk("flit_out", bus.flit_out, exp_flit);
    chk("drop_pulse", 64'(bus.drop_pulse), 64'(exp_drop));
    chk("sent_count", 64'(bus.sent_count), 64'(sent));
    chk("q_count", 64'(bus.q_count), 64'(q.size()));
  endtask
  task automatic step(input logic v, input logic [3:0] d, input logic [55:0] p, input logic f, output logic a);
    @(negedge clk);
    rst = 1'b0;
    bus.core_valid = v;
    bus.core_dest = d;
    bus.core_payload = p;
    bus.router_full = f;
    #1;
    chk("core_ready", 64'(bus.core_ready), 64'(q.size() < DEPTH));
    a = v && (q.size() < DEPTH);
    @(posedge clk);
    exp_wr = (q.size() > 0) && !f;
    if (exp_wr) begin
      exp_flit = q.pop_front();
      sent = sent + 16'd1;
    end
    if (a && d != SRC) q.push_back({p, d, SRC});
    exp_drop = a && (d == SRC);
    #1;
    compare_all();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.core_valid = 1'b1;
    bus.core_dest = 4'h3;
    #1;
    chk("core_ready_in_rst", 64'(bus.core_ready), 64'h0);
    @(posedge clk);
    q.delete();
    exp_flit = 64'h0;
    exp_wr = 1'b0;
    exp_drop = 1'b0;
    sent = 16'h0;
    #1;
    compare_all();
  endtask
  task automatic idle(input int n, input logic f);
    logic a;
    repeat (n) step(1'b0, 4'h0, 56'h0, f, a);
  endtask
  function automatic logic [3:0] rdest();
    logic [3:0] d;
    d = 4'($urandom_range(0, 15));
    return (d == SRC) ? d + 4'd1 : d;
  endfunction
  initial begin
    int wr_seen;
    logic [3:0] d5;
    logic [55:0] p5;
    bus.core_valid = 1'b0;
    bus.core_dest = 4'h0;
    bus.core_payload = 56'h0;
    bus.router_full = 1'b0;
    do_reset();
    do_reset();
    step(1'b1, 4'h3, 56'hABCDEF, 1'b0, acc);
    step(1'b0, 4'h0, 56'h0, 1'b0, acc);
    chk("req031_flit", bus.flit_out, 64'h0000_0000_ABCD_EF31);
    chk("req031_wr", 64'(bus.flit_wr_en), 64'h1);
    chk("req031_sent", 64'(bus.sent_count), 64'h1);
    idle(1, 1'b0);
    chk("req031_one_cycle", 64'(bus.flit_wr_en), 64'h0);
    for (int i = 0; i < 4; i++) step(1'b1, rdest(), 56'($urandom) << 24 | 56'($urandom), 1'b1, acc);
    chk("req032_q_full", 64'(bus.q_count), 64'h4);
    d5 = rdest();
    p5 = {24'($urandom), 32'($urandom)};
    step(1'b1, d5, p5, 1'b1, acc);
    chk("req032_fifth_blocked", 64'(acc), 64'h0);
    chk("req032_no_wr", 64'(bus.flit_wr_en), 64'h0);
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step(1'b1, d5, p5, 1'b0, acc);
    chk("req032_fifth_accepted", 64'(acc), 64'h1);
    idle(6, 1'b0);
    step(1'b1, SRC, 56'h123456, 1'b0, acc);
    chk("req033_drop", 64'(bus.drop_pulse), 64'h1);
    chk("req033_q", 64'(bus.q_count), 64'h0);
    idle(1, 1'b0);
    chk("req033_drop_one_cycle", 64'(bus.drop_pulse), 64'h0);
    chk("req033_no_wr", 64'(bus.flit_wr_en), 64'h0);
    do_reset();
    wr_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rdest(), {24'($urandom), 32'($urandom)}, 1'b0, acc);
      chk("req034_qmax", 64'(bus.q_count <= 4'd1), 64'h1);
      wr_seen += int'(bus.flit_wr_en);
    end
    step(1'b0, 4'h0, 56'h0, 1'b0, acc);
    wr_seen += int'(bus.flit_wr_en);
    chk("req034_wr_cycles", 64'(wr_seen), 64'd10);
    chk("req034_sent", 64'(bus.sent_count), 64'd10);
    for (int i = 0; i < 3; i++) step(1'b1, rdest(), {24'($urandom), 32'($urandom)}, 1'b1, acc);
    chk("req035_q3", 64'(bus.q_count), 64'h3);
    do_reset();
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0, 56'h0, 1'b0, acc);
      wr_seen += int'(bus.flit_wr_en);
    end
    chk("req035_no_emit", 64'(wr_seen), 64'h0);
    chk("req035_sent", 64'(bus.sent_count), 64'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), {24'($urandom), 32'($urandom)},
           $urandom_range(0, 2) == 0, acc);
    idle(6, 1'b0);
    do_reset();
    for (int i = 0; i < 65536; i++) step(1'b1, 4'h3, 56'(i), 1'b0, acc);
    idle(2, 1'b0);
    chk("req036_wrap", 64'(bus.sent_count), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
